uart_tx_buf: RTL and testbench
==============================

# uart_tx_buf

Buffered UART transmitter, the send-side counterpart of the loader's UART receive path. Accepts bytes from the core over a valid/ready handshake, holds them in a DEPTH-entry FIFO, and serialises them on UART_TX as 8N1 frames at CLK_PER_BIT clocks per bit. Sits between the core's output port and the board's UART_TX pin, and is used to return results and loader acknowledgements to the host.

## Interface
- CLK_PER_BIT, default 271: clock cycles per UART bit. Integer, ≥ 2.
- DEPTH, default 16: FIFO entries. Power of two, ≥ 2.
- CLK  in  1: system clock. All logic on the rising edge.
- RSTN  in  1: reset, asynchronous, active-low.
- DIN  in  8: byte to send.
- DIN_VALID  in  1: DIN holds a byte to send.
- DIN_READY  out  1: FIFO can accept a byte this cycle.
- UART_TX  out  1: serial line, registered, idles high.
- BUSY  out  1: FIFO non-empty or a frame is in progress.
- COUNT  out  $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.

## Operation
- Write handshake: byte accepted on a rising edge where DIN_VALID && DIN_READY. DIN_READY = (COUNT < DEPTH), derived from registered COUNT only. It never depends on a same-cycle pop.
- FIFO: circular buffer with rd/wr pointers of width $clog2(DEPTH), wrapping modulo DEPTH. COUNT is a registered value. On the same edge, push and pop give COUNT unchanged, push only gives +1, and pop only gives −1.
- When full, DIN_READY=0 and DIN is ignored. A pop on that edge does not allow a write on the same edge.
- Pop happens only when COUNT>0 and the FSM requests a new byte. The head byte is loaded into an 8-bit shift register.
- FSM states: IDLE, START, DATA, STOP. Bit timer counts 0..CLK_PER_BIT−1. Bit index counts 0..7.
  - IDLE: UART_TX=1. If COUNT>0, pop, then go to START.
  - START: UART_TX=0 for CLK_PER_BIT cycles, then go to DATA with index 0.
  - DATA: UART_TX = shift[0] for CLK_PER_BIT cycles, then shift right and increment the index. After index 7, go to STOP.
  - STOP: UART_TX=1 for CLK_PER_BIT cycles. At the end of STOP: if COUNT>0, pop and go to START (no idle gap). Otherwise go to IDLE.
- Bits are sent LSB first. There is no parity bit and exactly one stop bit.
- BUSY = (state != IDLE) || (COUNT != 0).

## Timing
- Reset values (applied asynchronously while RSTN=0): UART_TX=1, state=IDLE, COUNT=0, pointers=0, BUSY=0. DIN_READY=1, since it follows COUNT=0.
- Reset mid-frame: the line returns to 1 immediately, the partial frame is truncated, and FIFO contents are discarded. After RSTN rises, the block behaves as if freshly reset.
- Latency: byte accepted at edge E0 into an empty, idle block. Pop and START entry happen at E1, and UART_TX falls after E1.
- Frame duration is exactly 10·CLK_PER_BIT cycles from the UART_TX falling edge to the end of the stop bit.
- Back-to-back frames: with the FIFO non-empty, the next start bit begins on the cycle right after the last stop-bit cycle. The frame period is exactly 10·CLK_PER_BIT.
- COUNT decrements on the pop edge, which is the START entry edge, not at the end of the frame.
- DIN_READY re-asserts the cycle after a pop from full.

## Test plan
- Single byte, CLK_PER_BIT=271: push 0x55 → UART_TX falls 1 cycle after acceptance. Bit values are 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each held for 271 cycles. BUSY falls after 2710 cycles.
- Extreme bytes, CLK_PER_BIT=4: push 0x00 then 0xFF back-to-back → the 0x00 frame is line low for 36 cycles then high for 4. The 0xFF start bit follows immediately, then the line is high for 36 cycles. Total is 80 cycles with no gap.
- Full FIFO, DEPTH=16, CLK_PER_BIT=4: hold DIN_VALID with an incrementing byte from 0x00 → 17 bytes accepted (one is popped after the first), then DIN_READY=0 with COUNT=16. DIN_READY pulses high once per 40 cycles. The received stream is 0x00, 0x01, … in order with no loss or duplication.
- Simultaneous push and pop: push on the exact edge the FSM pops at the end of STOP → COUNT unchanged on that edge, and both bytes are transmitted in order.
- Reset mid-frame: assert RSTN=0 during DATA bit 3 with 5 bytes queued → UART_TX=1 immediately and COUNT=0. After release, there is no line activity until a new push. Pushing 0xA5 then produces one correct frame.
- Pointer wrap: stream 100 bytes 0x00..0x63 with DEPTH=4 and random DIN_VALID gaps → the decoded stream matches exactly, and COUNT never exceeds 4.

Source files
------------

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - Buffered 8N1 UART transmitter with a DEPTH-entry byte FIFO
module uart_tx_buf #(
  parameter int CLK_PER_BIT = 271,
  parameter int DEPTH       = 16
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [7:0]             DIN,
  input  logic                   DIN_VALID,
  output logic                   DIN_READY,
  output logic                   UART_TX,
  output logic                   BUSY,
  output logic [$clog2(DEPTH):0] COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(CLK_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLK_PER_BIT - 1);
  localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic          push, pop, bit_done;

  // Ready looks only at the registered occupancy, so a pop on the same edge
  // never opens a slot for a write.
  assign DIN_READY = (COUNT < FULL);
  assign push      = DIN_VALID && DIN_READY;
  assign BUSY      = (state != IDLE) || (COUNT != '0);
  assign bit_done  = (timer == T_LAST);

  // Byte storage; contents need no reset because COUNT gates every read.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= DIN;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   COUNT <= COUNT + 1'b1;
        2'b01:   COUNT <= COUNT - 1'b1;
        default: COUNT <= COUNT;
      endcase
    end
  end

  // Frame sequencer registers, including the registered serial line.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      UART_TX <= 1'b1;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      UART_TX <= tx_nxt;
    end
  end

  // Next-state logic; the line value is derived from the state being entered
  // so UART_TX changes on the same edge as the state.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop         = 1'b0;
    tx_nxt      = 1'b1;

    case (state)
      IDLE: begin
        if (COUNT != '0) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          timer_nxt = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_done) begin
          timer_nxt   = '0;
          bit_idx_nxt = '0;
          state_nxt   = DATA;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_nxt   = '0;
          shift_nxt   = {1'b0, shift[7:1]};
          bit_idx_nxt = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          timer_nxt = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (COUNT != '0) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - Self-checking bench for uart_tx_buf
module tb_uart_tx_buf;

  localparam int CPB_A = 271;
  localparam int CPB   = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance a: CLK_PER_BIT=271, DEPTH=16
  logic [7:0] din_a = '0;
  logic       val_a = 1'b0;
  logic       rdy_a, tx_a, busy_a;
  logic [4:0] cnt_a;
  // Instance b: CLK_PER_BIT=4, DEPTH=16
  logic [7:0] din_b = '0;
  logic       val_b = 1'b0;
  logic       rdy_b, tx_b, busy_b;
  logic [4:0] cnt_b;
  // Instance c: CLK_PER_BIT=4, DEPTH=4
  logic [7:0] din_c = '0;
  logic       val_c = 1'b0;
  logic       rdy_c, tx_c, busy_c;
  logic [2:0] cnt_c;

  uart_tx_buf #(.CLK_PER_BIT(CPB_A), .DEPTH(16)) u_a (
    .CLK(clk), .RSTN(rstn), .DIN(din_a), .DIN_VALID(val_a), .DIN_READY(rdy_a),
    .UART_TX(tx_a), .BUSY(busy_a), .COUNT(cnt_a)
  );
  uart_tx_buf #(.CLK_PER_BIT(CPB), .DEPTH(16)) u_b (
    .CLK(clk), .RSTN(rstn), .DIN(din_b), .DIN_VALID(val_b), .DIN_READY(rdy_b),
    .UART_TX(tx_b), .BUSY(busy_b), .COUNT(cnt_b)
  );
  uart_tx_buf #(.CLK_PER_BIT(CPB), .DEPTH(4)) u_c (
    .CLK(clk), .RSTN(rstn), .DIN(din_c), .DIN_VALID(val_c), .DIN_READY(rdy_c),
    .UART_TX(tx_c), .BUSY(busy_c), .COUNT(cnt_c)
  );

  // Expected line level for bit k of an 8N1 frame (0=start, 1..8 data LSB first, 9=stop)
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[k-1];
  endfunction

  // Serial receivers for instances b and c: mid-bit sampling decoder
  logic [7:0] rx_b[$];
  logic [7:0] rx_c[$];
  int         d_cnt[2];
  bit         d_act[2];
  logic [7:0] d_sh[2];
  logic       d_prev[2];
  int         frame_err[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      d_act[i] = 0; d_prev[i] = 1'b1; d_cnt[i] = 0; d_sh[i] = '0; frame_err[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic ln;
        ln = (i == 0) ? tx_b : tx_c;
        if (!rstn) begin
          d_act[i] = 0;
          ln = 1'b1;
        end else if (!d_act[i]) begin
          if (d_prev[i] && !ln) begin
            d_act[i] = 1;
            d_cnt[i] = 0;
          end
        end else begin
          d_cnt[i]++;
          if (d_cnt[i] == CPB / 2) begin
            if (ln) frame_err[i]++;
          end else if ((d_cnt[i] % CPB) == CPB / 2 && d_cnt[i] < 9 * CPB) begin
            d_sh[i] = {ln, d_sh[i][7:1]};
          end else if (d_cnt[i] == 9 * CPB + CPB / 2) begin
            if (!ln) frame_err[i]++;
            if (i == 0) rx_b.push_back(d_sh[i]);
            else        rx_c.push_back(d_sh[i]);
            d_act[i] = 0;
          end
        end
        d_prev[i] = ln;
      end
    end
  end

  task automatic wait_idle(input int which, input int budget);
    int n;
    n = 0;
    while (((which == 0) ? busy_b : busy_c) !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({tx_a, tx_b, tx_c} !== 3'b111) begin
      errors++; $display("FAIL reset_tx: got %b, required 111", {tx_a, tx_b, tx_c});
    end
    checks++;
    if (cnt_a !== 5'd0 || cnt_b !== 5'd0 || cnt_c !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %0d/%0d/%0d, required 0", cnt_a, cnt_b, cnt_c);
    end
    checks++;
    if ({rdy_a, rdy_b, rdy_c} !== 3'b111) begin
      errors++; $display("FAIL reset_ready: got %b, required 111", {rdy_a, rdy_b, rdy_c});
    end
    checks++;
    if ({busy_a, busy_b, busy_c} !== 3'b000) begin
      errors++; $display("FAIL reset_busy: got %b, required 000", {busy_a, busy_b, busy_c});
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: tx=%b busy=%b, required tx=1 busy=0", tx_b, busy_b);
    end
  endtask

  task automatic test_single_byte();
    int mism, bm;
    @(negedge clk);
    din_a = 8'h55; val_a = 1'b1;
    @(posedge clk);
    #1 val_a = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_a !== 1'b1 || cnt_a !== 5'd1) begin
      errors++; $display("FAIL single_accept: tx=%b count=%0d, required tx=1 count=1", tx_a, cnt_a);
    end
    @(posedge clk);
    bm = 0;
    for (int k = 0; k < 10; k++) begin
      mism = 0;
      repeat (CPB_A) begin
        @(negedge clk);
        if (tx_a !== frame_bit(8'h55, k)) mism++;
        if (busy_a !== 1'b1 || cnt_a !== 5'd0) bm++;
      end
      checks++;
      if (mism != 0) begin
        errors++; $display("FAIL single_bit%0d: %0d wrong cycles, required 0", k, mism);
      end
    end
    checks++;
    if (bm != 0) begin
      errors++; $display("FAIL single_busy_count: %0d wrong cycles in frame, required 0", bm);
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || tx_a !== 1'b1) begin
      errors++; $display("FAIL single_end: busy=%b tx=%b, required busy=0 tx=1", busy_a, tx_a);
    end
  endtask

  task automatic test_extremes();
    int   mism;
    logic e;
    rx_b.delete();
    @(negedge clk);
    din_b = 8'h00; val_b = 1'b1;
    @(posedge clk);
    #1 din_b = 8'hFF;
    @(posedge clk);
    #1 val_b = 1'b0;
    mism = 0;
    for (int k = 0; k < 20; k++) begin
      repeat (CPB) begin
        @(negedge clk);
        e = (k < 10) ? frame_bit(8'h00, k) : frame_bit(8'hFF, k - 10);
        if (tx_b !== e) mism++;
      end
    end
    checks++;
    if (mism != 0) begin
      errors++; $display("FAIL extremes_wave: %0d wrong cycles of 80, required 0", mism);
    end
    @(negedge clk);
    checks++;
    if (busy_b !== 1'b0 || tx_b !== 1'b1) begin
      errors++; $display("FAIL extremes_end: busy=%b tx=%b after 80 cycles, required 0/1", busy_b, tx_b);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rx_b.size() != 2 || rx_b[0] !== 8'h00 || rx_b[1] !== 8'hFF) begin
      errors++; $display("FAIL extremes_rx: %0d bytes received, required 00 FF", rx_b.size());
    end
  endtask

  task automatic test_full();
    logic [7:0] exp_q[$];
    int         acc, guard, cyc, ok;
    int         pulses[$];
    logic       r;
    rx_b.delete();
    acc = 0; guard = 0;
    @(negedge clk);
    din_b = 8'h00; val_b = 1'b1;
    while (rdy_b === 1'b1 && guard < 100) begin
      @(posedge clk);
      exp_q.push_back(din_b);
      acc++;
      #1 din_b = din_b + 8'd1;
      @(negedge clk);
      guard++;
    end
    checks++;
    if (acc != 17) begin
      errors++; $display("FAIL full_accepted: %0d bytes before stall, required 17", acc);
    end
    checks++;
    if (cnt_b !== 5'd16 || rdy_b !== 1'b0) begin
      errors++; $display("FAIL full_state: count=%0d ready=%b, required 16/0", cnt_b, rdy_b);
    end
    for (cyc = 0; cyc < 130; cyc++) begin
      @(negedge clk);
      r = rdy_b;
      if (r) pulses.push_back(cyc);
      @(posedge clk);
      if (r) begin
        exp_q.push_back(din_b);
        #1 din_b = din_b + 8'd1;
      end
    end
    ok = (pulses.size() >= 3);
    for (int i = 1; i < pulses.size(); i++) begin
      if (pulses[i] - pulses[i-1] != 10 * CPB) ok = 0;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL full_ready_pulse: %0d pulses with irregular spacing, required one per 40 cycles", pulses.size());
    end
    @(negedge clk);
    val_b = 1'b0;
    wait_idle(0, 2000);
    ok = (rx_b.size() == exp_q.size());
    for (int i = 0; i < rx_b.size() && i < exp_q.size(); i++) begin
      if (rx_b[i] !== exp_q[i]) ok = 0;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL full_stream: received %0d bytes, required %0d in order", rx_b.size(), exp_q.size());
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] x, y, z;
    x = 8'($urandom); y = 8'($urandom); z = 8'($urandom);
    rx_b.delete();
    @(negedge clk);
    din_b = x; val_b = 1'b1;
    @(posedge clk);
    #1 val_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    din_b = y; val_b = 1'b1;
    @(posedge clk);
    #1 val_b = 1'b0;
    repeat (38) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cnt_b !== 5'd1) begin
      errors++; $display("FAIL simul_before: count=%0d, required 1", cnt_b);
    end
    din_b = z; val_b = 1'b1;
    @(posedge clk);
    #1 val_b = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt_b !== 5'd1 || tx_b !== 1'b0) begin
      errors++; $display("FAIL simul_edge: count=%0d tx=%b, required count=1 tx=0", cnt_b, tx_b);
    end
    wait_idle(0, 500);
    checks++;
    if (rx_b.size() != 3 || rx_b[0] !== x || rx_b[1] !== y || rx_b[2] !== z) begin
      errors++; $display("FAIL simul_order: %0d bytes received, required %h %h %h", rx_b.size(), x, y, z);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d[6];
    int         mism;
    for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
    @(negedge clk);
    din_b = d[0]; val_b = 1'b1;
    for (int i = 1; i < 6; i++) begin
      @(posedge clk);
      #1 din_b = d[i];
    end
    @(posedge clk);
    #1 val_b = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cnt_b !== 5'd5 || tx_b !== d[0][3]) begin
      errors++; $display("FAIL resetmid_pre: count=%0d tx=%b, required 5/%b", cnt_b, tx_b, d[0][3]);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (tx_b !== 1'b1 || cnt_b !== 5'd0 || busy_b !== 1'b0 || rdy_b !== 1'b1) begin
      errors++; $display("FAIL resetmid_async: tx=%b count=%0d busy=%b ready=%b, required 1/0/0/1", tx_b, cnt_b, busy_b, rdy_b);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rx_b.delete();
    mism = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_b !== 1'b1 || busy_b !== 1'b0) mism++;
    end
    checks++;
    if (mism != 0) begin
      errors++; $display("FAIL resetmid_quiet: %0d active cycles after release, required 0", mism);
    end
    din_b = 8'hA5; val_b = 1'b1;
    @(posedge clk);
    #1 val_b = 1'b0;
    wait_idle(0, 200);
    checks++;
    if (rx_b.size() != 1 || rx_b[0] !== 8'hA5) begin
      errors++; $display("FAIL resetmid_frame: %0d bytes received, required one A5", rx_b.size());
    end
  endtask

  task automatic test_wrap();
    int maxc, gap, w, tmo, ok;
    rx_c.delete();
    maxc = 0; tmo = 0;
    for (int i = 0; i < 100; i++) begin
      gap = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 6));
      repeat (gap) begin
        @(negedge clk);
        if (int'(cnt_c) > maxc) maxc = int'(cnt_c);
      end
      @(negedge clk);
      din_c = 8'(i); val_c = 1'b1;
      w = 0;
      while (rdy_c !== 1'b1 && w < 200) begin
        if (int'(cnt_c) > maxc) maxc = int'(cnt_c);
        @(negedge clk);
        w++;
      end
      if (w >= 200) tmo++;
      if (int'(cnt_c) > maxc) maxc = int'(cnt_c);
      @(posedge clk);
      #1 val_c = 1'b0;
    end
    wait_idle(1, 5000);
    checks++;
    if (tmo != 0) begin
      errors++; $display("FAIL wrap_ready_timeout: %0d stalls, required 0", tmo);
    end
    checks++;
    if (maxc > 4) begin
      errors++; $display("FAIL wrap_count_max: %0d, required at most 4", maxc);
    end
    ok = (rx_c.size() == 100);
    for (int i = 0; i < rx_c.size(); i++) begin
      if (rx_c[i] !== 8'(i)) ok = 0;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL wrap_stream: %0d bytes received, required 0x00..0x63 in order", rx_c.size());
    end
  endtask

  task automatic test_framing();
    checks++;
    if (frame_err[0] != 0 || frame_err[1] != 0) begin
      errors++; $display("FAIL framing: %0d/%0d bad start or stop bits, required 0", frame_err[0], frame_err[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_extremes();
    test_full();
    test_simultaneous();
    test_reset_mid();
    test_wrap();
    test_framing();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
